// File: rtl/insn_fetch_memory_pkg.sv
// mspu_imem_pkg: shared widths and helpers for the banked instruction fetch memory
package mspu_imem_pkg;

    localparam int XLEN        = 32;
    localparam int BE_W        = 4;
    localparam int MAX_FETCH_W = 8;

    // Lane i of a fetch block is wanted when i >= offset; callers truncate to FETCH_W.
    function automatic logic [MAX_FETCH_W-1:0] lane_mask(input logic [2:0] offset);
        return {MAX_FETCH_W{1'b1}} << offset;
    endfunction

    function automatic logic addr_in_range(input logic [XLEN-1:0] addr, input int depth);
        return (addr >> (depth + 2)) == '0;
    endfunction

endpackage

// File: rtl/insn_fetch_memory_if.sv
// insn_fetch_memory_if: fetch request/response handshake plus loader write port
interface insn_fetch_memory_if #(parameter int FETCH_W = 2);
    import mspu_imem_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [XLEN-1:0]         req_pc;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [XLEN*FETCH_W-1:0] resp_insn;
    logic [FETCH_W-1:0]      resp_mask;
    logic [XLEN-1:0]         resp_pc;
    logic                    resp_err;
    logic                    flush;
    logic                    we;
    logic [XLEN-1:0]         wr_addr;
    logic [XLEN-1:0]         wr_data;
    logic [BE_W-1:0]         wr_be;

    modport master (
        output req_valid, req_pc, resp_ready, flush, we, wr_addr, wr_data, wr_be,
        input  req_ready, resp_valid, resp_insn, resp_mask, resp_pc, resp_err
    );

    modport slave (
        input  req_valid, req_pc, resp_ready, flush, we, wr_addr, wr_data, wr_be,
        output req_ready, resp_valid, resp_insn, resp_mask, resp_pc, resp_err
    );

endinterface

// File: rtl/insn_fetch_memory_bank.sv
// insn_bank: one interleaved word bank, read-first registered read, byte-enabled write
module insn_bank
    import mspu_imem_pkg::*;
#(
    parameter  int ROWS_LOG2 = 11,
    localparam int AW        = ROWS_LOG2 > 0 ? ROWS_LOG2 : 1
) (
    input  logic            clk,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] dout,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [BE_W-1:0] be
);

    logic [XLEN-1:0] mem [2**AW];

    // dout only moves on a read, so a stalled response never re-reads the array
    always_ff @(posedge clk) begin
        if (re) dout <= mem[raddr];
        for (int b = 0; b < BE_W; b++)
            if (we && be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

endmodule

// File: rtl/insn_fetch_memory.sv
// insn_fetch_memory: banked instruction memory serving FETCH_W-wide fetch blocks
module insn_fetch_memory
    import mspu_imem_pkg::*;
#(
    parameter int DEPTH   = 12,
    parameter int FETCH_W = 2
) (
    input logic                 clk,
    input logic                 reset,
    insn_fetch_memory_if.slave  bus
);

    localparam int LW        = $clog2(FETCH_W);
    localparam int ROWS_LOG2 = DEPTH - LW;
    localparam int AW        = ROWS_LOG2 > 0 ? ROWS_LOG2 : 1;

    logic [DEPTH-1:0]               rd_word, wr_word, rd_off, wr_bank;
    logic [AW-1:0]                  rd_row, wr_row;
    logic                           accept, req_err, wr_ok;
    logic                           valid_q, err_q, insn_ok_q;
    logic [FETCH_W-1:0]             mask_q;
    logic [XLEN-1:0]                pc_q;
    logic [FETCH_W-1:0][XLEN-1:0]   dout;

    assign rd_word = bus.req_pc[DEPTH+1:2];
    assign wr_word = bus.wr_addr[DEPTH+1:2];
    assign rd_off  = rd_word & DEPTH'(FETCH_W - 1);
    assign wr_bank = wr_word & DEPTH'(FETCH_W - 1);
    assign rd_row  = AW'(rd_word >> LW);
    assign wr_row  = AW'(wr_word >> LW);
    assign req_err = bus.req_pc[1:0] != 2'b00 || !addr_in_range(bus.req_pc, DEPTH);
    assign wr_ok   = bus.we && addr_in_range(bus.wr_addr, DEPTH);

    assign bus.req_ready = !bus.flush && (!valid_q || bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            insn_ok_q <= 1'b0;
            mask_q    <= '0;
            pc_q      <= '0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            err_q     <= req_err;
            insn_ok_q <= !req_err;
            mask_q    <= req_err ? '0 : FETCH_W'(lane_mask(3'(rd_off)));
            pc_q      <= bus.req_pc;
        end else if (bus.flush || bus.resp_ready) begin
            valid_q   <= 1'b0;
        end
    end

    for (genvar i = 0; i < FETCH_W; i++) begin : g_bank
        insn_bank #(.ROWS_LOG2(ROWS_LOG2)) u_bank (
            .clk   (clk),
            .re    (accept),
            .raddr (rd_row),
            .dout  (dout[i]),
            .we    (wr_ok && wr_bank == DEPTH'(i)),
            .waddr (wr_row),
            .wdata (bus.wr_data),
            .be    (bus.wr_be)
        );
    end

    // Lane data is gated so reset and error responses read as zero regardless of bank contents
    assign bus.resp_insn  = insn_ok_q ? dout : '0;
    assign bus.resp_valid = valid_q;
    assign bus.resp_mask  = mask_q;
    assign bus.resp_pc    = pc_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_insn_fetch_memory.sv
// tb_insn_fetch_memory: directed and randomized checks against a word-array reference model
module tb_insn_fetch_memory;

    localparam int DEPTH = 4;
    localparam int FW    = 2;
    localparam int WORDS = 2**DEPTH;
    localparam int RW    = 2 + FW + 32 + 32*FW;

    logic clk = 1'b0;
    logic reset;
    int compared = 0;
    int mismatched = 0;
    logic [31:0] mem_m [WORDS];

    always #5 clk = ~clk;

    insn_fetch_memory_if #(.FETCH_W(FW)) bus ();

    insn_fetch_memory #(.DEPTH(DEPTH), .FETCH_W(FW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Expected {valid, err, mask, pc, insn} for a fetch of pc against the current model memory
    function automatic logic [RW-1:0] model_resp(input logic [31:0] pc);
        logic [FW-1:0] m;
        logic [32*FW-1:0] ins;
        int w;
        if (pc % 4 != 0 || pc >= 32'(4*WORDS)) return {1'b1, 1'b1, {FW{1'b0}}, pc, {32*FW{1'b0}}};
        w = int'(pc / 4);
        for (int i = 0; i < FW; i++) begin
            m[i] = i >= w % FW;
            ins[32*i +: 32] = mem_m[w - w % FW + i];
        end
        return {1'b1, 1'b0, m, pc, ins};
    endfunction

    function automatic logic [RW-1:0] observed();
        return {bus.resp_valid, bus.resp_err, bus.resp_mask, bus.resp_pc, bus.resp_insn};
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        if (addr < 32'(4*WORDS))
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[addr / 4][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 0; bus.req_pc = 0; bus.resp_ready = 1; bus.flush = 0;
        bus.we = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_be = 0;
    endtask

    task automatic test_reset();
        logic [RW-1:0] got;
        idle();
        reset = 1;
        step(); step();
        reset = 0;
        #1;
        got = observed();
        compared++;
        if (got !== '0) begin mismatched++; $display("FAIL reset_outputs got=%h exp=0", got); end
        compared++;
        if (bus.req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_load();
        for (int i = 0; i < WORDS; i++) begin
            bus.we = 1; bus.wr_addr = 32'(4*i); bus.wr_data = 32'h1000_0000 + 32'(i); bus.wr_be = 4'hF;
            model_write(bus.wr_addr, bus.wr_data, bus.wr_be);
            step();
        end
        bus.we = 0;
    endtask

    task automatic test_fetch();
        logic [31:0] pcs [$];
        logic [RW-1:0] exp_r, got;
        pcs = '{32'h08, 32'h0C};
        for (int k = 0; k < 8; k++) pcs.push_back(32'($urandom_range(0, WORDS-1)) * 4);
        foreach (pcs[k]) begin
            bus.req_valid = 1; bus.req_pc = pcs[k]; bus.resp_ready = 1;
            exp_r = model_resp(pcs[k]);
            step();
            bus.req_valid = 0;
            got = observed();
            compared++;
            if (got !== exp_r) begin mismatched++; $display("FAIL fetch pc=%h got=%h exp=%h", pcs[k], got, exp_r); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3] = '{32'h00, 32'h08, 32'h10};
        logic [RW-1:0] exp_r, got;
        bus.resp_ready = 1;
        foreach (pcs[k]) begin
            bus.req_valid = 1; bus.req_pc = pcs[k];
            #1;
            compared++;
            if (bus.req_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready pc=%h got=%b exp=1", pcs[k], bus.req_ready); end
            exp_r = model_resp(pcs[k]);
            @(posedge clk); #1;
            got = observed();
            compared++;
            if (got !== exp_r) begin mismatched++; $display("FAIL b2b pc=%h got=%h exp=%h", pcs[k], got, exp_r); end
        end
        bus.req_valid = 0;
        step();
    endtask

    task automatic test_error();
        logic [31:0] pcs [$];
        logic [RW-1:0] exp_r, got;
        pcs = '{32'h06, 32'h40, 32'h8000_0000, 32'h01, 32'h4_0000};
        bus.resp_ready = 1;
        foreach (pcs[k]) begin
            bus.req_valid = 1; bus.req_pc = pcs[k];
            exp_r = model_resp(pcs[k]);
            step();
            bus.req_valid = 0;
            got = observed();
            compared++;
            if (got !== exp_r) begin mismatched++; $display("FAIL err_fetch pc=%h got=%h exp=%h", pcs[k], got, exp_r); end
        end
        bus.we = 1; bus.wr_addr = 32'h40; bus.wr_data = 32'hFFFF_FFFF; bus.wr_be = 4'hF;
        model_write(bus.wr_addr, bus.wr_data, bus.wr_be);
        step();
        bus.we = 0;
        for (int b = 0; b < WORDS / FW; b++) begin
            bus.req_valid = 1; bus.req_pc = 32'(4*FW*b);
            exp_r = model_resp(bus.req_pc);
            step();
            got = observed();
            compared++;
            if (got !== exp_r) begin mismatched++; $display("FAIL oob_write_block%0d got=%h exp=%h", b, got, exp_r); end
        end
        bus.req_valid = 0;
        step();
    endtask

    task automatic test_stall_write();
        logic [RW-1:0] exp_r, got;
        bus.req_valid = 1; bus.req_pc = 0; bus.resp_ready = 0;
        exp_r = model_resp(0);
        step();
        bus.req_pc = 32'h08;
        for (int k = 0; k < 3; k++) begin
            bus.we = 1; bus.wr_addr = 0; bus.wr_data = 32'hDEAD_BEEF; bus.wr_be = 4'hF;
            #1;
            compared++;
            if (bus.req_ready !== 1'b0) begin mismatched++; $display("FAIL stall_ready cyc%0d got=%b exp=0", k, bus.req_ready); end
            got = observed();
            compared++;
            if (got !== exp_r) begin mismatched++; $display("FAIL stall_hold cyc%0d got=%h exp=%h", k, got, exp_r); end
            model_write(bus.wr_addr, bus.wr_data, bus.wr_be);
            @(posedge clk); #1;
        end
        bus.we = 0;
        got = observed();
        compared++;
        if (got !== exp_r) begin mismatched++; $display("FAIL stall_hold_end got=%h exp=%h", got, exp_r); end
        bus.req_valid = 0; bus.resp_ready = 1;
        step();
        compared++;
        if (bus.resp_valid !== 1'b0) begin mismatched++; $display("FAIL stall_release got=%b exp=0", bus.resp_valid); end
        bus.req_valid = 1; bus.req_pc = 0;
        exp_r = model_resp(0);
        step();
        bus.req_valid = 0;
        got = observed();
        compared++;
        if (got !== exp_r) begin mismatched++; $display("FAIL after_stall_write got=%h exp=%h", got, exp_r); end
        step();
    endtask

    task automatic test_collision();
        logic [RW-1:0] exp_r, got;
        bus.req_valid = 1; bus.req_pc = 32'h04; bus.resp_ready = 1;
        bus.we = 1; bus.wr_addr = 32'h04; bus.wr_data = 32'hAABB_CCDD; bus.wr_be = 4'b0011;
        exp_r = model_resp(32'h04);
        model_write(bus.wr_addr, bus.wr_data, bus.wr_be);
        step();
        bus.we = 0;
        got = observed();
        compared++;
        if (got !== exp_r) begin mismatched++; $display("FAIL collision_old got=%h exp=%h", got, exp_r); end
        exp_r = model_resp(32'h04);
        step();
        bus.req_valid = 0;
        got = observed();
        compared++;
        if (got !== exp_r) begin mismatched++; $display("FAIL collision_new got=%h exp=%h", got, exp_r); end
        step();
    endtask

    task automatic test_flush();
        bus.req_valid = 1; bus.req_pc = 32'h08; bus.resp_ready = 0;
        step();
        bus.flush = 1; bus.req_pc = 32'h10;
        #1;
        compared++;
        if (bus.req_ready !== 1'b0) begin mismatched++; $display("FAIL flush_ready got=%b exp=0", bus.req_ready); end
        @(posedge clk); #1;
        bus.flush = 0; bus.req_valid = 0;
        compared++;
        if (bus.resp_valid !== 1'b0) begin mismatched++; $display("FAIL flush_valid got=%b exp=0", bus.resp_valid); end
        step();
        compared++;
        if (bus.resp_valid !== 1'b0) begin mismatched++; $display("FAIL flush_idle got=%b exp=0", bus.resp_valid); end
        bus.resp_ready = 1;
    endtask

    task automatic test_reset_midstream();
        logic [RW-1:0] got;
        bus.req_valid = 1; bus.req_pc = 32'h00; bus.resp_ready = 0;
        step();
        bus.req_pc = 32'h08; bus.resp_ready = 1; reset = 1;
        step();
        reset = 0; bus.req_valid = 0;
        got = observed();
        compared++;
        if (got !== '0) begin mismatched++; $display("FAIL reset_mid got=%h exp=0", got); end
        step();
        got = observed();
        compared++;
        if (got !== '0) begin mismatched++; $display("FAIL reset_mid_next got=%h exp=0", got); end
    endtask

    task automatic test_random();
        logic exp_valid = 0;
        logic exp_ready;
        logic [RW-1:0] exp_r = '0, got;
        for (int c = 0; c < 300; c++) begin
            bus.req_valid  = $urandom_range(0, 3) != 0;
            bus.req_pc     = $urandom_range(0, 9) == 0 ? $urandom_range(0, 31'h7FFF_FFFF) :
                             $urandom_range(0, 9) == 0 ? 32'($urandom_range(0, 80)) :
                             32'($urandom_range(0, WORDS-1)) * 4;
            bus.resp_ready = $urandom_range(0, 2) != 0;
            bus.flush      = $urandom_range(0, 11) == 0;
            bus.we         = $urandom_range(0, 1);
            bus.wr_addr    = 32'($urandom_range(0, WORDS + 3)) * 4 + 32'($urandom_range(0, 3));
            bus.wr_data    = $urandom;
            bus.wr_be      = 4'($urandom_range(0, 15));
            #1;
            exp_ready = !bus.flush && (!exp_valid || bus.resp_ready);
            compared++;
            if (bus.req_ready !== exp_ready) begin mismatched++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready); end
            if (bus.req_valid && exp_ready) begin
                exp_r = model_resp(bus.req_pc);
                exp_valid = 1;
            end else if (bus.flush || bus.resp_ready) begin
                exp_valid = 0;
            end
            if (bus.we) model_write(bus.wr_addr, bus.wr_data, bus.wr_be);
            @(posedge clk); #1;
            got = observed();
            compared++;
            if (exp_valid ? got !== exp_r : bus.resp_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL rnd_resp c=%0d got=%h exp=%h exp_valid=%b", c, got, exp_r, exp_valid);
            end
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_back_to_back();
        test_error();
        test_stall_write();
        test_collision();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
